// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the PE feeder slice: default parameter values for
// the element width, PE column count, buffer depth and systolic step length,
// plus the feeder FSM state type.
// ---------------------------------------------------------------------------
package pe_pkg;

  localparam int DEF_ELEMENT_BITS = 8;
  localparam int DEF_P            = 4;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_STEP_CYCLES  = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } feeder_state_t;

  // Larger of two elaboration-time integers, used to size shared counters.
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_feed_fifo.sv
// ---------------------------------------------------------------------------
// pe_feed_fifo
// Synchronous FIFO that buffers {weight row, input element} entries ahead of
// the PE array. The head entry is presented combinationally on o_data.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (empties the FIFO)
//   i_push   write i_data this cycle (ignored while full)
//   i_data   entry to write
//   i_pop    drop the head entry this cycle (ignored while empty)
//   o_data   current head entry
//   o_full   count == DEPTH
//   o_empty  count == 0
//   o_count  number of stored entries
// ---------------------------------------------------------------------------
module pe_feed_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH-1)) ? '0 : ptr + AW'(1);
  endfunction

  assign w_doPush = i_push && (r_count != CW'(DEPTH));
  assign w_doPop  = i_pop  && (r_count != '0);

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/pe_feeder.sv
// ---------------------------------------------------------------------------
// pe_feeder
// Buffers weight rows and input elements from a producer and streams one
// tile of them into a systolic PE array, one entry per systolic step, then
// drains the array with P-1 zero steps.
//
// Ports
//   sys_clk          rising-edge clock
//   reset_n          asynchronous active-low reset
//   in_valid         producer offers an entry
//   in_ready         buffer has room (transfer on in_valid && in_ready)
//   in_weight        weight row of the offered entry
//   in_input         input element of the offered entry
//   tile_len         entries per tile, sampled when start is accepted
//   start            request to stream one tile
//   weight_data_out  weight row driven to the PE array
//   input_data_out   input element driven to the PE array
//   pe_step          one-cycle pulse advancing the PE array
//   busy             tile in progress (RUN, FLUSH, DONE)
//   done             one-cycle pulse at tile completion
//   start_err        one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module pe_feeder
  import pe_pkg::*;
#(
  parameter int ELEMENT_BITS = DEF_ELEMENT_BITS,
  parameter int P            = DEF_P,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STEP_CYCLES  = DEF_STEP_CYCLES
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [P*ELEMENT_BITS-1:0]    in_weight,
  input  logic [ELEMENT_BITS-1:0]      in_input,
  input  logic [$clog2(DEPTH+1)-1:0]   tile_len,
  input  logic                         start,
  output logic [P*ELEMENT_BITS-1:0]    weight_data_out,
  output logic [ELEMENT_BITS-1:0]      input_data_out,
  output logic                         pe_step,
  output logic                         busy,
  output logic                         done,
  output logic                         start_err
);

  localparam int WW         = P*ELEMENT_BITS;
  localparam int FW         = WW + ELEMENT_BITS;
  localparam int TLW        = $clog2(DEPTH+1);
  localparam int SCW        = $clog2(STEP_CYCLES);
  localparam int CW         = maxOf(TLW, $clog2(P+1));
  localparam int FLUSH_LAST = (P > 1) ? P-2 : 0;

  feeder_state_t     r_state;
  feeder_state_t     w_nextState;
  logic [SCW-1:0]    r_stepCnt;
  logic [CW-1:0]     r_stepIdx;
  logic [TLW-1:0]    r_tileLen;
  logic [WW-1:0]     r_weightOut;
  logic [ELEMENT_BITS-1:0] r_inputOut;
  logic              r_peStep;
  logic              r_startErr;

  logic [FW-1:0]     w_head;
  logic              w_full;
  logic              w_empty;
  logic [TLW-1:0]    w_count;
  logic              w_pop;
  logic              w_accept;
  logic              w_reject;
  logic              w_stepFire;
  logic              w_startOk;
  logic              w_lastRun;
  logic              w_lastFlush;

  pe_feed_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (reset_n),
    .i_push  (in_valid),
    .i_data  ({in_weight, in_input}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign in_ready = !w_full;

  // A systolic step happens on the last cycle of each STEP_CYCLES window
  // while streaming or draining.
  assign w_stepFire  = ((r_state == RUN) || (r_state == FLUSH)) &&
                       (r_stepCnt == SCW'(STEP_CYCLES-1));
  assign w_startOk   = (tile_len != '0) && (w_count >= tile_len);
  assign w_lastRun   = (r_stepIdx == (CW'(r_tileLen) - CW'(1)));
  assign w_lastFlush = (r_stepIdx == CW'(FLUSH_LAST));

  // Next-state and control decode. Start is only looked at in IDLE, so a
  // start held through a tile has no effect and raises no error.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_startOk) begin
            w_nextState = RUN;
            w_accept    = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_stepFire) begin
          w_pop = !w_empty;
          if (w_lastRun) w_nextState = (P == 1) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (w_stepFire && w_lastFlush) w_nextState = DONE;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, step timing and the per-phase step index. The index counts RUN
  // steps, then restarts at zero to count FLUSH steps.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_stepCnt  <= '0;
      r_stepIdx  <= '0;
      r_tileLen  <= '0;
      r_peStep   <= 1'b0;
      r_startErr <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_peStep   <= w_stepFire;
      r_startErr <= w_reject;
      if (w_accept) begin
        r_tileLen <= tile_len;
        r_stepCnt <= '0;
        r_stepIdx <= '0;
      end else if ((r_state == RUN) || (r_state == FLUSH)) begin
        r_stepCnt <= w_stepFire ? '0 : r_stepCnt + SCW'(1);
        if (w_stepFire) begin
          r_stepIdx <= ((r_state == RUN) && w_lastRun) ? '0 : r_stepIdx + CW'(1);
        end
      end
    end
  end

  // Data outputs change only on a step: the popped head in RUN, zeros in
  // FLUSH. They hold otherwise.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_weightOut <= '0;
      r_inputOut  <= '0;
    end else if (w_stepFire) begin
      if (r_state == RUN) begin
        r_weightOut <= w_head[FW-1 -: WW];
        r_inputOut  <= w_head[ELEMENT_BITS-1:0];
      end else begin
        r_weightOut <= '0;
        r_inputOut  <= '0;
      end
    end
  end

  assign weight_data_out = r_weightOut;
  assign input_data_out  = r_inputOut;
  assign pe_step         = r_peStep;
  assign start_err       = r_startErr;
  assign busy            = (r_state != IDLE);
  assign done            = (r_state == DONE);

endmodule

// File: tb/tb_pe_feeder.sv
// ---------------------------------------------------------------------------
// tb_pe_feeder
// Directed self-checking bench for pe_feeder. A queue of pushed entries
// serves as the reference for what each RUN step must present.
// ---------------------------------------------------------------------------
module tb_pe_feeder;
  import pe_pkg::*;

  localparam int EB    = DEF_ELEMENT_BITS;
  localparam int PC    = DEF_P;
  localparam int DEPTH = DEF_DEPTH;
  localparam int SC    = DEF_STEP_CYCLES;
  localparam int WW    = PC*EB;
  localparam int TLW   = $clog2(DEPTH+1);

  logic              sys_clk   = 1'b0;
  logic              reset_n   = 1'b0;
  logic              in_valid  = 1'b0;
  logic [WW-1:0]     in_weight = '0;
  logic [EB-1:0]     in_input  = '0;
  logic [TLW-1:0]    tile_len  = '0;
  logic              start     = 1'b0;
  logic              in_ready;
  logic [WW-1:0]     weight_data_out;
  logic [EB-1:0]     input_data_out;
  logic              pe_step;
  logic              busy;
  logic              done;
  logic              start_err;

  int total   = 0;
  int bad     = 0;
  int pushSeq = 0;
  logic [WW+EB-1:0] model [$];

  pe_feeder dut (
    .sys_clk         (sys_clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_weight       (in_weight),
    .in_input        (in_input),
    .tile_len        (tile_len),
    .start           (start),
    .weight_data_out (weight_data_out),
    .input_data_out  (input_data_out),
    .pe_step         (pe_step),
    .busy            (busy),
    .done            (done),
    .start_err       (start_err)
  );

  always #5 sys_clk = ~sys_clk;

  // One comparison: bumps the total, and on mismatch the failure count.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Push one entry and record it in the reference queue.
  task automatic applyStimulus(input logic [WW-1:0] w, input logic [EB-1:0] x);
    checkOutput("in_ready_before_push", in_ready, 1);
    in_valid  = 1'b1;
    in_weight = w;
    in_input  = x;
    @(negedge sys_clk);
    in_valid  = 1'b0;
    model.push_back({w, x});
  endtask

  // A start that must be refused: one start_err pulse, no steps, stays idle.
  task automatic tryBadStart(input int n);
    tile_len = TLW'(n);
    start    = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    checkOutput("start_err_pulse", start_err, 1);
    checkOutput("busy_after_reject", busy, 0);
    @(negedge sys_clk);
    checkOutput("start_err_one_cycle", start_err, 0);
    for (int k = 0; k < 2*SC; k++) begin
      @(negedge sys_clk);
      checkOutput("no_step_after_reject", pe_step, 0);
      checkOutput("idle_after_reject", busy, 0);
    end
  endtask

  // Accepted tile of n entries, checked every cycle. Optionally pushes a new
  // entry after each RUN step, holds start through RUN, or stops early.
  task automatic runTile(input int n, input bit pushDuring, input bit holdStart,
                         input int abortAt);
    int               steps;
    int               last;
    int               j;
    logic             isStep;
    logic [WW-1:0]    expW;
    logic [EB-1:0]    expX;
    logic [WW+EB-1:0] e;
    steps = n + PC - 1;
    last  = SC*steps;
    expW  = '0;
    expX  = '0;
    j     = 0;
    tile_len = TLW'(n);
    start    = 1'b1;
    @(negedge sys_clk);
    if (!holdStart) start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("no_err_on_accept", start_err, 0);
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge sys_clk);
      in_valid = 1'b0;
      isStep = ((k % SC) == 0) && (k <= last);
      if (isStep) begin
        j = k / SC;
        if (j <= n) begin
          e    = model.pop_front();
          expW = e[WW+EB-1:EB];
          expX = e[EB-1:0];
        end else begin
          expW = '0;
          expX = '0;
        end
      end
      checkOutput("pe_step", pe_step, isStep);
      checkOutput("weight_data_out", weight_data_out, expW);
      checkOutput("input_data_out", input_data_out, expX);
      checkOutput("done", done, k == last);
      checkOutput("busy", busy, k <= last);
      checkOutput("start_err_in_tile", start_err, 0);
      if (holdStart && k == SC*n) start = 1'b0;
      if (pushDuring && isStep && j <= n) begin
        checkOutput("in_ready_after_pop", in_ready, 1);
        in_valid  = 1'b1;
        in_weight = WW'(100 + pushSeq);
        in_input  = EB'(200 + pushSeq);
        model.push_back({in_weight, in_input});
        pushSeq++;
      end
      if (abortAt != 0 && k == abortAt) return;
    end
  endtask

  // Directed sequence covering reset, normal tiles, rejected starts, a full
  // buffer with concurrent pushes, mid-tile reset and back-to-back tiles.
  initial begin
    // Reset state
    repeat (2) @(negedge sys_clk);
    checkOutput("rst_weight", weight_data_out, 0);
    checkOutput("rst_input", input_data_out, 0);
    checkOutput("rst_pe_step", pe_step, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_start_err", start_err, 0);
    reset_n = 1'b1;
    @(negedge sys_clk);
    checkOutput("in_ready_out_of_reset", in_ready, 1);

    // Basic tile of four entries
    for (int i = 0; i < 4; i++) applyStimulus(WW'(i), EB'(i + 30));
    runTile(4, 1'b0, 1'b0, 0);
    $display("[TB] basic tile finished");

    // Too few entries, then one more makes the same start legal
    for (int i = 0; i < 3; i++) applyStimulus(WW'(10 + i), EB'(40 + i));
    tryBadStart(4);
    applyStimulus(WW'(13), EB'(43));
    runTile(4, 1'b0, 1'b0, 0);

    // Zero-length start refused; start held through a tile is ignored
    tryBadStart(0);
    applyStimulus(WW'(32'hA1B2C3D4), EB'(8'h55));
    applyStimulus(WW'(32'h01020304), EB'(8'hAA));
    runTile(2, 1'b0, 1'b1, 0);

    // Fill the buffer, try an extra push, then stream while refilling
    for (int i = 0; i < DEPTH; i++) applyStimulus(WW'(32'h1000 + i), EB'(i));
    checkOutput("in_ready_full", in_ready, 0);
    in_valid  = 1'b1;
    in_weight = WW'(32'hEEEE);
    in_input  = EB'(8'hEE);
    repeat (2) @(negedge sys_clk);
    in_valid = 1'b0;
    checkOutput("in_ready_still_full", in_ready, 0);
    runTile(DEPTH, 1'b1, 1'b0, 0);
    checkOutput("in_ready_refilled", in_ready, 0);
    runTile(DEPTH, 1'b0, 1'b0, 0);
    tryBadStart(1);
    $display("[TB] full buffer tiles finished");

    // Reset after the second step of an eight-entry tile
    for (int i = 0; i < 8; i++) applyStimulus(WW'(50 + i), EB'(60 + i));
    runTile(8, 1'b0, 1'b0, 2*SC + 2);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_weight", weight_data_out, 0);
    checkOutput("abort_input", input_data_out, 0);
    checkOutput("abort_pe_step", pe_step, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    model.delete();
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      checkOutput("abort_no_done", done, 0);
    end
    checkOutput("abort_in_ready", in_ready, 1);
    tryBadStart(1);
    for (int i = 0; i < 4; i++) applyStimulus(WW'(i), EB'(i + 30));
    runTile(4, 1'b0, 1'b0, 0);

    // Back-to-back short tiles leave the remainder queued
    for (int i = 0; i < 6; i++) applyStimulus(WW'(32'h700 + i), EB'(70 + i));
    runTile(2, 1'b0, 1'b0, 0);
    runTile(2, 1'b0, 1'b0, 0);
    tryBadStart(3);
    runTile(2, 1'b0, 1'b0, 0);
    tryBadStart(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter ELEMENT_BITS, default 8, width of one data element.
REQ-002 Parameter P, default 4, PE columns; weight row width is P*ELEMENT_BITS.
REQ-003 Parameter DEPTH, default 16, buffer entries (max tile length).
REQ-004 Parameter STEP_CYCLES, default 5, sys_clk cycles per systolic step (≥2).
REQ-005 sys_clk  in  1  single clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  producer offers one entry.
REQ-008 in_ready  out  1  buffer can accept; transfer occurs when in_valid && in_ready.
REQ-009 in_weight  in  P*ELEMENT_BITS  weight row of the entry.
REQ-010 in_input  in  ELEMENT_BITS  input element of the entry.
REQ-011 tile_len  in  $clog2(DEPTH+1)  entries per tile; sampled on accepted start.
REQ-012 start  in  1  request to stream one tile.
REQ-013 weight_data_out  out  P*ELEMENT_BITS  weight row to the PE array.
REQ-014 input_data_out  out  ELEMENT_BITS  input element to the PE array.
REQ-015 pe_step  out  1  one-cycle pulse; the PE array advances one step on it.
REQ-016 busy  out  1  high in RUN, FLUSH and DONE.
REQ-017 done  out  1  one-cycle pulse at tile completion.
REQ-018 start_err  out  1  one-cycle pulse when start is rejected.

Function
REQ-019 Buffer: FIFO of DEPTH entries {in_weight, in_input}; in_ready = (count < DEPTH); pushes accepted in every state.
REQ-020 A push and a pop in the same cycle leave count unchanged; a push while full is impossible because in_ready is low.
REQ-021 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-022 IDLE->RUN on start when tile_len != 0 and count >= tile_len; step counter and entry counter are cleared.
REQ-023 In IDLE, a start with tile_len == 0 or count < tile_len pulses start_err the next cycle and leaves the FSM in IDLE.
REQ-024 start is ignored (no error pulse) outside IDLE.
REQ-025 The step counter runs 0..STEP_CYCLES-1 in RUN/FLUSH and wraps; a step fires when it equals STEP_CYCLES-1, so the first step occurs STEP_CYCLES cycles after start is accepted.
REQ-026 RUN step: pop the FIFO head; register it onto weight_data_out/input_data_out at that edge, with pe_step high for exactly that cycle.
REQ-027 After tile_len RUN steps the FSM enters FLUSH, which lasts P-1 further steps that drive zeros with pe_step pulses (array drain).
REQ-028 If P == 1, RUN goes directly to DONE.
REQ-029 The last FLUSH step leads to DONE for one cycle (done=1), then IDLE.
REQ-030 Data outputs hold their values between steps; they return to zero only through a FLUSH step or reset.
REQ-031 Entries pushed during a tile remain queued for the next tile; they are never popped beyond tile_len.

Reset
REQ-032 On reset_n low, asynchronously: FSM=IDLE, FIFO empty (count=0), counters 0, all data outputs 0, pe_step/done/start_err/busy 0; in_ready=1 once out of reset.
REQ-033 Reset during RUN/FLUSH aborts the tile; no done pulse; buffered entries are discarded.

Structure
REQ-034 Package pe_pkg holds ELEMENT_BITS, P, DEPTH and STEP_CYCLES defaults, and the state enum feeder_state_t.
REQ-035 The FIFO is the sub-module pe_feed_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count); FSM and step timing stay in pe_feeder.

Verification
REQ-036 Push 4 entries (weight=i, input=i+30, i=0..3), tile_len=4, start -> pe_step every 5 cycles, first at cycle 5; outputs 0/30,1/31,2/32,3/33; 3 zero steps; done once; busy low after.
REQ-037 tile_len=4 with only 3 entries, start -> start_err one pulse, no pe_step, FSM stays IDLE; a 4th push then start -> normal run.
REQ-038 Fill 16 entries -> in_ready=0 and extra in_valid ignored; run tile_len=16 while pushing on every step -> count stays 16 until the push stream stops, no data lost or reordered.
REQ-039 Assert reset_n low after the 2nd step of a tile_len=8 run -> all outputs 0 immediately, no done pulse, count=0, and a fresh run afterwards behaves like REQ-036.
REQ-040 Push 6 entries, tile_len=2 twice back-to-back -> second tile emits entries 2,3; 2 entries remain (count=2).
REQ-041 start with tile_len=0 -> start_err pulse; start held during RUN -> no effect, no error.
